decode_stage: RTL and testbench

- Instruction-decode pipeline stage, directly upstream of register_file; drives its read addresses and consumes its read data.
- Holds the IF/ID register, decodes the MIPS-I subset into control, detects load-use hazards and bypasses same-cycle writeback.
- Produces a registered ID/EX bundle for the execute stage.

---
 rtl/mips_pkg.sv | 49 ++++
 rtl/decode_stage_if.sv | 23 ++
 rtl/decode_stage_decoder.sv | 101 ++++++++++
 rtl/decode_stage.sv | 149 ++++++++++++++
 tb/tb_decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU operation encodings and the packed
// control word shared by the decode stage, its decoder and the execute stage.
package mips_pkg;

  localparam int CTRL_W = 12;

  // Control word bit positions; these match the field order of ctrl_t below.
  localparam int C_REG_WRITE = 11;
  localparam int C_MEM_READ  = 10;
  localparam int C_MEM_WRITE = 9;
  localparam int C_ALU_SRC   = 8;
  localparam int C_BR_EQ     = 7;
  localparam int C_BR_NE     = 6;
  localparam int C_JUMP      = 5;
  localparam int C_LINK      = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR  = 4'd4,  ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,  ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    br_eq;
    logic    br_ne;
    logic    jump;
    logic    link;
    alu_op_e alu_op;
  } ctrl_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] F_SLL = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03,
                         F_JR  = 6'h08, F_ADD  = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR  = 6'h25, F_XOR  = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: registered ID/EX bundle from decode to execute.
//   master (decode_stage): drives every field
//   slave  (execute)     : consumes every field
interface decode_stage_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RSEL  = 5
);
  logic              valid;
  logic [WIDTH-1:0]  pc4;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic [WIDTH-1:0]  imm;
  logic [RSEL-1:0]   rs;
  logic [RSEL-1:0]   rt;
  logic [RSEL-1:0]   dest;
  logic [CTRL_W-1:0] ctrl;
  logic              illegal;

  modport master (output valid, pc4, rs_data, rt_data, imm, rs, rt, dest, ctrl, illegal);
  modport slave  (input  valid, pc4, rs_data, rt_data, imm, rs, rt, dest, ctrl, illegal);
endinterface

// File: rtl/decode_stage_decoder.sv
// instr_decoder: purely combinational MIPS-I subset decoder.
//   i_instr   : instruction word
//   o_ctrl    : packed control (all zero for unsupported encodings)
//   o_dest    : destination register (rd, rt or 31 for jal)
//   o_imm     : extended immediate (sign, zero or lui-shifted)
//   o_illegal : unsupported opcode/funct
//   o_uses_rt : rt is a source operand (gates the load-use check on rt)
module instr_decoder
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output ctrl_t       o_ctrl,
  output logic [4:0]  o_dest,
  output logic [31:0] o_imm,
  output logic        o_illegal,
  output logic        o_uses_rt
);
  logic [5:0] w_op, w_fn;
  logic [4:0] w_rt, w_rd;

  assign w_op = i_instr[31:26];
  assign w_fn = i_instr[5:0];
  assign w_rt = i_instr[20:16];
  assign w_rd = i_instr[15:11];

  always_comb begin
    o_ctrl    = '0;
    o_dest    = '0;
    o_illegal = 1'b0;
    o_uses_rt = 1'b0;
    o_imm     = {{16{i_instr[15]}}, i_instr[15:0]};
    case (w_op)
      OP_RTYPE: begin
        o_dest           = w_rd;
        o_uses_rt        = 1'b1;
        o_ctrl.reg_write = 1'b1;
        case (w_fn)
          F_ADD, F_ADDU: o_ctrl.alu_op = ALU_ADD;
          F_SUB, F_SUBU: o_ctrl.alu_op = ALU_SUB;
          F_AND:         o_ctrl.alu_op = ALU_AND;
          F_OR:          o_ctrl.alu_op = ALU_OR;
          F_XOR:         o_ctrl.alu_op = ALU_XOR;
          F_NOR:         o_ctrl.alu_op = ALU_NOR;
          F_SLT:         o_ctrl.alu_op = ALU_SLT;
          F_SLTU:        o_ctrl.alu_op = ALU_SLTU;
          F_SLL:         o_ctrl.alu_op = ALU_SLL;
          F_SRL:         o_ctrl.alu_op = ALU_SRL;
          F_SRA:         o_ctrl.alu_op = ALU_SRA;
          F_JR: begin
            o_ctrl.reg_write = 1'b0;
            o_ctrl.jump      = 1'b1;
            o_uses_rt        = 1'b0;
          end
          default:       o_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
        o_dest           = w_rt;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_read  = (w_op == OP_LW);
        case (w_op)
          OP_SLTI: o_ctrl.alu_op = ALU_SLT;
          OP_ANDI: begin o_ctrl.alu_op = ALU_AND; o_imm = {16'h0, i_instr[15:0]}; end
          OP_ORI:  begin o_ctrl.alu_op = ALU_OR;  o_imm = {16'h0, i_instr[15:0]}; end
          OP_LUI:  begin o_ctrl.alu_op = ALU_LUI; o_imm = {i_instr[15:0], 16'h0}; end
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_SW: begin
        o_dest           = w_rt;
        o_uses_rt        = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        // Offset stays unshifted; execute applies the <<2.
        o_dest         = w_rt;
        o_uses_rt      = 1'b1;
        o_ctrl.br_eq   = (w_op == OP_BEQ);
        o_ctrl.br_ne   = (w_op == OP_BNE);
        o_ctrl.alu_op  = ALU_SUB;
      end
      OP_J:   o_ctrl.jump = 1'b1;
      OP_JAL: begin
        o_dest           = 5'd31;
        o_ctrl.jump      = 1'b1;
        o_ctrl.link      = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) begin
      o_ctrl    = '0;
      o_dest    = '0;
      o_uses_rt = 1'b0;
    end
    // $0 is hardwired; never let anything claim to write it.
    if (o_dest == 5'd0) o_ctrl.reg_write = 1'b0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID register, instruction decode, load-use hazard detection
// and writeback bypass; produces the registered ID/EX bundle.
//   clk, rst                 : clock, synchronous active-low reset
//   if_valid/if_instr/if_pc  : fetch input, held by fetch while if_stall=1
//   flush                    : kill IF/ID and ID/EX (beats hazard and hold)
//   ex_hold                  : freeze IF/ID and ID/EX
//   ex_mem_read/ex_dest      : load currently in ID/EX and its destination
//   wb_write/wb_reg/wb_data  : writeback port, bypassed into operand reads
//   rf_read_reg1/2           : rs/rt of IF/ID to register_file (combinational)
//   rf_read_data1/2          : register_file read data
//   if_stall                 : fetch must hold
//   id_ex                    : ID/EX bundle (master side)
module decode_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RSEL  = 5
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             flush,
  input  logic             ex_hold,
  input  logic             ex_mem_read,
  input  logic [RSEL-1:0]  ex_dest,
  input  logic             wb_write,
  input  logic [RSEL-1:0]  wb_reg,
  input  logic [WIDTH-1:0] wb_data,
  output logic [RSEL-1:0]  rf_read_reg1,
  output logic [RSEL-1:0]  rf_read_reg2,
  input  logic [WIDTH-1:0] rf_read_data1,
  input  logic [WIDTH-1:0] rf_read_data2,
  output logic             if_stall,
  decode_stage_if.master   id_ex
);
  logic             r_ifid_valid;
  logic [31:0]      r_ifid_instr;
  logic [WIDTH-1:0] r_ifid_pc;

  logic             r_valid, r_illegal;
  logic [WIDTH-1:0] r_pc4, r_rs_data, r_rt_data, r_imm;
  logic [RSEL-1:0]  r_rs, r_rt, r_dest;
  ctrl_t            r_ctrl;

  ctrl_t            w_ctrl;
  logic [4:0]       w_dest;
  logic [31:0]      w_imm;
  logic             w_illegal, w_uses_rt, w_hazard, w_stall;
  logic [RSEL-1:0]  w_rs, w_rt;
  logic [WIDTH-1:0] w_rs_data, w_rt_data;

  assign w_rs         = RSEL'(r_ifid_instr[25:21]);
  assign w_rt         = RSEL'(r_ifid_instr[20:16]);
  assign rf_read_reg1 = w_rs;
  assign rf_read_reg2 = w_rt;

  instr_decoder u_dec (
    .i_instr   (r_ifid_instr),
    .o_ctrl    (w_ctrl),
    .o_dest    (w_dest),
    .o_imm     (w_imm),
    .o_illegal (w_illegal),
    .o_uses_rt (w_uses_rt)
  );

  // Writeback in the same cycle as the read would otherwise be missed by
  // register_file's registered write, so forward it here.
  function automatic logic [WIDTH-1:0] f_read(
    input logic [RSEL-1:0] sel, input logic [WIDTH-1:0] rf_data,
    input logic wbw, input logic [RSEL-1:0] wbr, input logic [WIDTH-1:0] wbd);
    if (sel == '0)                 return '0;
    else if (wbw && (wbr == sel))  return wbd;
    else                           return rf_data;
  endfunction

  always_comb begin
    w_rs_data = f_read(w_rs, rf_read_data1, wb_write, wb_reg, wb_data);
    w_rt_data = f_read(w_rt, rf_read_data2, wb_write, wb_reg, wb_data);
  end

  // id_ex_valid qualifies ex_mem_read so a bubble never looks like a load.
  assign w_hazard = r_ifid_valid & ex_mem_read & r_valid & (ex_dest != '0) &
                    ((ex_dest == w_rs) | ((ex_dest == w_rt) & w_uses_rt));
  assign w_stall  = w_hazard | ex_hold;
  assign if_stall = w_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc    <= '0;
    end else if (flush) begin
      r_ifid_valid <= 1'b0;
    end else if (!w_stall) begin
      r_ifid_valid <= if_valid;
      r_ifid_instr <= if_instr;
      r_ifid_pc    <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_ctrl    <= '0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_dest    <= '0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_ctrl    <= '0;
    end else if (!ex_hold) begin
      if (w_hazard || !r_ifid_valid) begin
        r_valid   <= 1'b0;
        r_illegal <= 1'b0;
        r_ctrl    <= '0;
      end else begin
        r_valid   <= 1'b1;
        r_illegal <= w_illegal;
        r_ctrl    <= w_ctrl;
        r_pc4     <= r_ifid_pc + WIDTH'(4);
        r_rs_data <= w_rs_data;
        r_rt_data <= w_rt_data;
        r_imm     <= WIDTH'(w_imm);
        r_rs      <= w_rs;
        r_rt      <= w_rt;
        r_dest    <= RSEL'(w_dest);
      end
    end
  end

  assign id_ex.valid   = r_valid;
  assign id_ex.illegal = r_illegal;
  assign id_ex.ctrl    = r_ctrl;
  assign id_ex.pc4     = r_pc4;
  assign id_ex.rs_data = r_rs_data;
  assign id_ex.rt_data = r_rt_data;
  assign id_ex.imm     = r_imm;
  assign id_ex.rs      = r_rs;
  assign id_ex.rt      = r_rt;
  assign id_ex.dest    = r_dest;
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_valid, flush, ex_hold, ex_mem_read, wb_write, if_stall;
  logic [31:0] if_instr, if_pc, wb_data, rf_read_data1, rf_read_data2;
  logic [4:0]  ex_dest, wb_reg, rf_read_reg1, rf_read_reg2;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.WIDTH(32), .RSEL(5)) idx ();

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .ex_hold(ex_hold), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .wb_write(wb_write), .wb_reg(wb_reg), .wb_data(wb_data),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .if_stall(if_stall), .id_ex(idx)
  );

  // Reference decode built straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ins, output logic [11:0] ctrl,
                                     output logic [4:0] dest, output logic [31:0] imm,
                                     output logic ill);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic rw = 0, mr = 0, mw = 0, as = 0, be = 0, bn = 0, jp = 0, lk = 0;
    logic [3:0] alu = 0;
    ill  = 0;
    dest = 0;
    imm  = {{16{ins[15]}}, ins[15:0]};
    case (op)
      6'h00: begin
        dest = ins[15:11]; rw = 1;
        case (fn)
          6'h20, 6'h21: alu = 0;
          6'h22, 6'h23: alu = 1;
          6'h24: alu = 2;  6'h25: alu = 3;  6'h26: alu = 4;  6'h27: alu = 5;
          6'h2A: alu = 6;  6'h2B: alu = 7;  6'h00: alu = 8;  6'h02: alu = 9;
          6'h03: alu = 10;
          6'h08: begin rw = 0; jp = 1; end
          default: ill = 1;
        endcase
      end
      6'h08, 6'h09: begin dest = ins[20:16]; rw = 1; as = 1; end
      6'h0A: begin dest = ins[20:16]; rw = 1; as = 1; alu = 6; end
      6'h0C: begin dest = ins[20:16]; rw = 1; as = 1; alu = 2; imm = {16'h0, ins[15:0]}; end
      6'h0D: begin dest = ins[20:16]; rw = 1; as = 1; alu = 3; imm = {16'h0, ins[15:0]}; end
      6'h0F: begin dest = ins[20:16]; rw = 1; as = 1; alu = 11; imm = {ins[15:0], 16'h0}; end
      6'h23: begin dest = ins[20:16]; rw = 1; mr = 1; as = 1; end
      6'h2B: begin dest = ins[20:16]; mw = 1; as = 1; end
      6'h04: begin dest = ins[20:16]; be = 1; alu = 1; end
      6'h05: begin dest = ins[20:16]; bn = 1; alu = 1; end
      6'h02: jp = 1;
      6'h03: begin dest = 31; jp = 1; lk = 1; rw = 1; end
      default: ill = 1;
    endcase
    if (ill) begin {rw, mr, mw, as, be, bn, jp, lk} = 0; alu = 0; end
    if (dest == 0) rw = 0;
    ctrl = {rw, mr, mw, as, be, bn, jp, lk, alu};
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r, input logic [31:0] rf,
                                           input logic wbw, input logic [4:0] wbr,
                                           input logic [31:0] wbd);
    if (r == 0) return 0;
    if (wbw && wbr == r) return wbd;
    return rf;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [5:0] ops [13] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23,
                             6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};
    int k = $urandom_range(0, 17);
    if (k < 13) w[31:26] = ops[k];
    else begin
      w[31:26] = 6'h00;
      w[5:0]   = fns[$urandom_range(0, 14)];
    end
    return w;
  endfunction

  task automatic idle();
    if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; ex_hold = 0;
    ex_mem_read = 0; ex_dest = 0; wb_write = 0; wb_reg = 0; wb_data = 0;
    rf_read_data1 = 0; rf_read_data2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; idle();
    if_valid = 1; if_instr = 32'h2008FFFF; if_pc = 32'h100; ex_hold = 0;
    tick(); tick();
    n_chk++; if (idx.valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", idx.valid); else n_pass++;
    n_chk++; if (idx.ctrl !== 12'h0) $display("FAIL rst_ctrl got %h exp 000", idx.ctrl); else n_pass++;
    n_chk++;
    if ({idx.pc4, idx.imm, idx.rs_data, idx.rt_data, idx.rs, idx.rt, idx.dest, idx.illegal} !== '0)
      $display("FAIL rst_fields got pc4 %h imm %h dest %h ill %b exp all 0",
               idx.pc4, idx.imm, idx.dest, idx.illegal);
    else n_pass++;
    n_chk++; if (if_stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", if_stall); else n_pass++;
    n_chk++; if (rf_read_reg2 !== 5'd0) $display("FAIL rst_ifid got %h exp 00", rf_read_reg2); else n_pass++;
    rst = 1; idle();
    tick();
  endtask

  task automatic test_addi();
    if_valid = 1; if_instr = 32'h2008FFFF; if_pc = 32'h100;
    tick(); idle(); #1;
    n_chk++;
    if ({rf_read_reg1, rf_read_reg2} !== {5'd0, 5'd8})
      $display("FAIL addi_rfsel got %h/%h exp 00/08", rf_read_reg1, rf_read_reg2);
    else n_pass++;
    n_chk++; if (idx.valid !== 1'b0) $display("FAIL addi_latency got valid %b exp 0", idx.valid); else n_pass++;
    tick();
    n_chk++; if (idx.imm !== 32'hFFFFFFFF) $display("FAIL addi_imm got %h exp ffffffff", idx.imm); else n_pass++;
    n_chk++; if (idx.dest !== 5'd8) $display("FAIL addi_dest got %h exp 08", idx.dest); else n_pass++;
    n_chk++; if (idx.pc4 !== 32'h104) $display("FAIL addi_pc4 got %h exp 104", idx.pc4); else n_pass++;
    n_chk++; if (idx.ctrl !== 12'h900) $display("FAIL addi_ctrl got %h exp 900", idx.ctrl); else n_pass++;
    n_chk++; if (idx.valid !== 1'b1) $display("FAIL addi_valid got %b exp 1", idx.valid); else n_pass++;
  endtask

  task automatic test_load_use();
    idle();
    if_valid = 1; if_instr = 32'h8D090000; if_pc = 32'h200;   // lw $9,0($8)
    tick();
    if_instr = 32'h01295020; if_pc = 32'h204;                 // add $10,$9,$9
    tick();
    ex_mem_read = 1; ex_dest = 9; #1;
    n_chk++; if (idx.ctrl !== 12'hD00) $display("FAIL lu_lw_ctrl got %h exp d00", idx.ctrl); else n_pass++;
    n_chk++; if (if_stall !== 1'b1) $display("FAIL lu_stall got %b exp 1", if_stall); else n_pass++;
    tick();
    n_chk++; if ({idx.valid, idx.ctrl} !== 13'h0) $display("FAIL lu_bubble got v%b c%h exp v0 c000", idx.valid, idx.ctrl); else n_pass++;
    n_chk++; if (if_stall !== 1'b0) $display("FAIL lu_stall_drop got %b exp 0", if_stall); else n_pass++;
    n_chk++; if (rf_read_reg1 !== 5'd9) $display("FAIL lu_hold_ifid got %h exp 09", rf_read_reg1); else n_pass++;
    ex_mem_read = 0; ex_dest = 0; if_valid = 0;
    tick();
    n_chk++;
    if ({idx.valid, idx.dest, idx.ctrl, idx.pc4} !== {1'b1, 5'd10, 12'h800, 32'h208})
      $display("FAIL lu_add_issue got v%b d%h c%h pc4 %h exp v1 d0a c800 pc4 208",
               idx.valid, idx.dest, idx.ctrl, idx.pc4);
    else n_pass++;
  endtask

  task automatic test_bypass();
    idle();
    if_valid = 1; if_instr = 32'h21230005; if_pc = 32'h300;   // addi $3,$9,5
    tick();
    wb_write = 1; wb_reg = 9; wb_data = 32'hDEADBEEF; rf_read_data1 = 0; rf_read_data2 = 32'h1234;
    if_instr = 32'h01272020;                                  // add $4,$9,$7
    tick();
    n_chk++; if (idx.rs_data !== 32'hDEADBEEF) $display("FAIL byp_rs got %h exp deadbeef", idx.rs_data); else n_pass++;
    n_chk++; if (idx.rt_data !== 32'h1234) $display("FAIL byp_rt_nomatch got %h exp 00001234", idx.rt_data); else n_pass++;
    wb_reg = 7; wb_data = 32'hCAFEF00D; rf_read_data1 = 32'h11111111; rf_read_data2 = 0;
    if_instr = 32'h20030005;                                  // addi $3,$0,5
    tick();
    n_chk++;
    if ({idx.rs_data, idx.rt_data} !== {32'h11111111, 32'hCAFEF00D})
      $display("FAIL byp_rt got %h/%h exp 11111111/cafef00d", idx.rs_data, idx.rt_data);
    else n_pass++;
    wb_reg = 0; wb_data = 32'hDEADBEEF; rf_read_data1 = 32'h55; if_valid = 0;
    tick();
    n_chk++; if (idx.rs_data !== 32'h0) $display("FAIL byp_r0 got %h exp 00000000", idx.rs_data); else n_pass++;
  endtask

  task automatic test_flush_stall();
    idle();
    if_valid = 1; if_instr = 32'h8D090000; if_pc = 32'h400;
    tick();
    if_instr = 32'h01295020; if_pc = 32'h404;
    tick();
    ex_mem_read = 1; ex_dest = 9; #1;
    n_chk++; if (if_stall !== 1'b1) $display("FAIL fl_pre_stall got %b exp 1", if_stall); else n_pass++;
    flush = 1;
    tick();
    flush = 0; if_valid = 0; #1;
    n_chk++; if ({idx.valid, idx.ctrl} !== 13'h0) $display("FAIL fl_idex got v%b c%h exp v0 c000", idx.valid, idx.ctrl); else n_pass++;
    n_chk++; if (if_stall !== 1'b0) $display("FAIL fl_stall got %b exp 0", if_stall); else n_pass++;
    tick();
    n_chk++; if (idx.valid !== 1'b0) $display("FAIL fl_ifid_killed got %b exp 0", idx.valid); else n_pass++;
    idle();
  endtask

  task automatic test_hold();
    idle();
    if_valid = 1; if_instr = 32'h34C58001; if_pc = 32'h500;   // ori $5,$6,0x8001
    tick();
    if_instr = 32'h3C071234; if_pc = 32'h504;                 // lui $7,0x1234
    tick();
    ex_hold = 1; if_instr = 32'hAD0A0004; if_pc = 32'h508;    // sw $10,4($8)
    #1;
    n_chk++; if (if_stall !== 1'b1) $display("FAIL hold_stall got %b exp 1", if_stall); else n_pass++;
    tick(); tick();
    n_chk++;
    if ({idx.imm, idx.dest, idx.ctrl} !== {32'h00008001, 5'd5, 12'h903})
      $display("FAIL hold_idex got imm %h d%h c%h exp 00008001 d05 c903", idx.imm, idx.dest, idx.ctrl);
    else n_pass++;
    n_chk++; if (rf_read_reg2 !== 5'd7) $display("FAIL hold_ifid got %h exp 07", rf_read_reg2); else n_pass++;
    ex_hold = 0;
    tick();
    n_chk++;
    if ({idx.imm, idx.dest, idx.ctrl} !== {32'h12340000, 5'd7, 12'h90B})
      $display("FAIL hold_lui got imm %h d%h c%h exp 12340000 d07 c90b", idx.imm, idx.dest, idx.ctrl);
    else n_pass++;
    if_valid = 0;
    tick();
    n_chk++;
    if ({idx.valid, idx.imm, idx.ctrl} !== {1'b1, 32'h4, 12'h300})
      $display("FAIL hold_sw got v%b imm %h c%h exp v1 00000004 c300", idx.valid, idx.imm, idx.ctrl);
    else n_pass++;
  endtask

  task automatic test_illegal_jal();
    idle();
    if_valid = 1; if_instr = 32'hFC000000; if_pc = 32'h600;
    tick();
    if_instr = 32'h0C000040; if_pc = 32'h604;
    tick();
    n_chk++;
    if ({idx.valid, idx.illegal, idx.ctrl} !== {1'b1, 1'b1, 12'h0})
      $display("FAIL illegal got v%b ill%b c%h exp v1 ill1 c000", idx.valid, idx.illegal, idx.ctrl);
    else n_pass++;
    if_valid = 0;
    tick();
    n_chk++;
    if ({idx.dest, idx.ctrl, idx.illegal, idx.pc4} !== {5'd31, 12'h830, 1'b0, 32'h608})
      $display("FAIL jal got d%h c%h ill%b pc4 %h exp d1f c830 ill0 pc4 608",
               idx.dest, idx.ctrl, idx.illegal, idx.pc4);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0]  cur_i, cur_pc, nxt_i, nxt_pc, e_imm, e_rs, e_rt;
    logic         cur_v, nxt_v, e_ill;
    logic [11:0]  e_ctrl;
    logic [4:0]   e_dest, rs, rt;
    logic [119:0] got, exp;
    idle();
    tick();
    cur_v = 0; cur_i = 0; cur_pc = 0;
    for (int k = 0; k < 300; k++) begin
      rs = cur_i[25:21]; rt = cur_i[20:16];
      rf_read_data1 = $urandom; rf_read_data2 = $urandom;
      wb_write = 1'($urandom_range(0, 1)); wb_data = $urandom;
      case ($urandom_range(0, 3))
        0: wb_reg = rs;
        1: wb_reg = rt;
        2: wb_reg = 0;
        default: wb_reg = 5'($urandom);
      endcase
      ref_decode(cur_i, e_ctrl, e_dest, e_imm, e_ill);
      e_rs = ref_read(rs, rf_read_data1, wb_write, wb_reg, wb_data);
      e_rt = ref_read(rt, rf_read_data2, wb_write, wb_reg, wb_data);
      nxt_v = ($urandom_range(0, 3) != 0); nxt_i = rand_instr(); nxt_pc = $urandom & 32'hFFFFFFFC;
      if_valid = nxt_v; if_instr = nxt_i; if_pc = nxt_pc;
      #1;
      n_chk++;
      if ({rf_read_reg1, rf_read_reg2, if_stall} !== {rs, rt, 1'b0})
        $display("FAIL rnd_sel[%0d] got %h/%h st%b exp %h/%h st0", k, rf_read_reg1, rf_read_reg2, if_stall, rs, rt);
      else n_pass++;
      tick();
      if (cur_v) begin
        got = {idx.valid, idx.pc4, idx.rs_data, idx.rt_data, idx.rs, idx.rt, idx.ctrl, idx.illegal};
        exp = {1'b1, cur_pc + 32'd4, e_rs, e_rt, rs, rt, e_ctrl, e_ill};
        n_chk++;
        if (got !== exp) $display("FAIL rnd_bundle[%0d] instr %h got %h exp %h", k, cur_i, got, exp);
        else n_pass++;
        if (!e_ill) begin
          n_chk++;
          if ({idx.dest, idx.imm} !== {e_dest, e_imm})
            $display("FAIL rnd_dest_imm[%0d] instr %h got %h/%h exp %h/%h", k, cur_i, idx.dest, idx.imm, e_dest, e_imm);
          else n_pass++;
        end
      end else begin
        n_chk++;
        if ({idx.valid, idx.ctrl, idx.illegal} !== 14'h0)
          $display("FAIL rnd_bubble[%0d] got v%b c%h ill%b exp all 0", k, idx.valid, idx.ctrl, idx.illegal);
        else n_pass++;
      end
      cur_v = nxt_v; cur_i = nxt_i; cur_pc = nxt_pc;
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_addi();
    test_load_use();
    test_bypass();
    test_flush_stall();
    test_hold();
    test_illegal_jal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
